alu_issue_arbiter: RTL and testbench

ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

---
 rtl/alu_issue_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_issue_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// Two-requester round-robin issue arbiter feeding one ALU exe unit through a single
// holding register, with branch-mask tracking, mispredict/flush kill and a kill counter.
module alu_issue_arbiter (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_req_0_valid,
    output logic        io_req_0_ready,
    input  logic [6:0]  io_req_0_bits_rob_idx,
    input  logic [6:0]  io_req_0_bits_pdst,
    input  logic [19:0] io_req_0_bits_br_mask,
    input  logic        io_req_1_valid,
    output logic        io_req_1_ready,
    input  logic [6:0]  io_req_1_bits_rob_idx,
    input  logic [6:0]  io_req_1_bits_pdst,
    input  logic [19:0] io_req_1_bits_br_mask,
    output logic        io_exe_valid,
    input  logic        io_exe_ready,
    output logic [6:0]  io_exe_bits_rob_idx,
    output logic [6:0]  io_exe_bits_pdst,
    output logic [19:0] io_exe_bits_br_mask,
    output logic        io_exe_bits_src,
    input  logic [19:0] io_brupdate_b1_resolve_mask,
    input  logic [19:0] io_brupdate_b1_mispredict_mask,
    input  logic        io_flush,
    output logic [15:0] io_kill_count
);
    localparam int unsigned ROB_W  = 7;
    localparam int unsigned PDST_W = 7;
    localparam int unsigned MASK_W = 20;
    localparam int unsigned CNT_W  = 16;

    typedef struct packed {
        logic [ROB_W-1:0]  rob_idx;
        logic [PDST_W-1:0] pdst;
        logic [MASK_W-1:0] br_mask;
        logic              src;
    } uop_t;

    logic             valid_q;
    uop_t             held_q;
    logic             rr_q;
    logic [CNT_W-1:0] kill_q;

    logic              held_kill;
    logic              reg_free;
    logic              grant_0;
    logic              grant_1;
    logic              granted;
    logic              in_kill;
    logic              kill_event;
    logic [MASK_W-1:0] in_mask;
    uop_t              in_uop;

    // Grant and kill decisions for this cycle
    always_comb begin
        held_kill  = 1'b0;
        reg_free   = 1'b0;
        grant_0    = 1'b0;
        grant_1    = 1'b0;
        granted    = 1'b0;
        in_kill    = 1'b0;
        kill_event = 1'b0;
        in_mask    = io_req_0_bits_br_mask;
        in_uop     = '0;

        held_kill = valid_q && ((|(held_q.br_mask & io_brupdate_b1_mispredict_mask)) || io_flush);
        reg_free  = !valid_q || io_exe_ready || held_kill;

        if (reg_free && !io_flush && !reset) begin
            if (io_req_0_valid && io_req_1_valid) begin
                grant_0 = !rr_q;
                grant_1 = rr_q;
            end else begin
                grant_0 = io_req_0_valid;
                grant_1 = io_req_1_valid;
            end
        end
        granted = grant_0 || grant_1;

        if (grant_1) begin
            in_mask        = io_req_1_bits_br_mask;
            in_uop.rob_idx = io_req_1_bits_rob_idx;
            in_uop.pdst    = io_req_1_bits_pdst;
        end else begin
            in_uop.rob_idx = io_req_0_bits_rob_idx;
            in_uop.pdst    = io_req_0_bits_pdst;
        end
        in_uop.br_mask = in_mask & ~io_brupdate_b1_resolve_mask;
        in_uop.src     = grant_1;

        in_kill    = granted && (|(in_mask & io_brupdate_b1_mispredict_mask));
        kill_event = held_kill || in_kill;
    end

    // Control state: valid bit, round-robin pointer, saturating kill counter
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            rr_q    <= 1'b0;
            kill_q  <= '0;
        end else begin
            if (granted && !in_kill) begin
                valid_q <= 1'b1;
            end else if (reg_free) begin
                valid_q <= 1'b0;
            end
            if (granted) begin
                rr_q <= !grant_1;
            end
            if (kill_event && (kill_q != {CNT_W{1'b1}})) begin
                kill_q <= kill_q + CNT_W'(1);
            end
        end
    end

    // Payload holds or tracks resolved branches; contents are don't-care while empty
    always_ff @(posedge clock) begin
        if (granted && !in_kill) begin
            held_q <= in_uop;
        end else begin
            held_q.br_mask <= held_q.br_mask & ~io_brupdate_b1_resolve_mask;
        end
    end

    assign io_req_0_ready      = grant_0;
    assign io_req_1_ready      = grant_1;
    assign io_exe_valid        = valid_q;
    assign io_exe_bits_rob_idx = held_q.rob_idx;
    assign io_exe_bits_pdst    = held_q.pdst;
    assign io_exe_bits_br_mask = held_q.br_mask;
    assign io_exe_bits_src     = held_q.src;
    assign io_kill_count       = kill_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed vector table, randomized run against a
// behavioural model, and kill-counter saturation.
module tb_alu_issue_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1, r0, r1, exe_rdy, ev, esrc, flush;
    logic [6:0]  rob0, rob1, pdst0, pdst1, erob, epdst;
    logic [19:0] m0, m1, emask, res, mis;
    logic [15:0] kcnt;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    bit          md_valid;
    bit [6:0]    md_rob, md_pdst;
    bit [19:0]   md_mask;
    bit          md_src;
    int          md_rr;
    int          md_kill;

    always #5 clk = ~clk;

    alu_issue_arbiter dut (
        .clock                          (clk),
        .reset                          (rst),
        .io_req_0_valid                 (v0),
        .io_req_0_ready                 (r0),
        .io_req_0_bits_rob_idx          (rob0),
        .io_req_0_bits_pdst             (pdst0),
        .io_req_0_bits_br_mask          (m0),
        .io_req_1_valid                 (v1),
        .io_req_1_ready                 (r1),
        .io_req_1_bits_rob_idx          (rob1),
        .io_req_1_bits_pdst             (pdst1),
        .io_req_1_bits_br_mask          (m1),
        .io_exe_valid                   (ev),
        .io_exe_ready                   (exe_rdy),
        .io_exe_bits_rob_idx            (erob),
        .io_exe_bits_pdst               (epdst),
        .io_exe_bits_br_mask            (emask),
        .io_exe_bits_src                (esrc),
        .io_brupdate_b1_resolve_mask    (res),
        .io_brupdate_b1_mispredict_mask (mis),
        .io_flush                       (flush),
        .io_kill_count                  (kcnt)
    );

    typedef struct {
        logic        v0;
        logic [6:0]  rob0;
        logic [19:0] m0;
        logic        v1;
        logic [6:0]  rob1;
        logic [19:0] m1;
        logic        rdy;
        logic [19:0] res;
        logic [19:0] mis;
        logic        flush;
        logic        er0;
        logic        er1;
        logic        ev;
        logic [6:0]  erob;
        logic [19:0] emask;
        logic        esrc;
        logic [15:0] ekill;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic a_v0, input int a_rob0, input int a_m0,
                                input logic a_v1, input int a_rob1, input int a_m1,
                                input logic a_rdy, input int a_res, input int a_mis,
                                input logic a_fl, input logic x_r0, input logic x_r1,
                                input logic x_ev, input int x_rob, input int x_mask,
                                input logic x_src, input int x_kill);
        vec_t t;
        t.v0 = a_v0; t.rob0 = 7'(a_rob0); t.m0 = 20'(a_m0);
        t.v1 = a_v1; t.rob1 = 7'(a_rob1); t.m1 = 20'(a_m1);
        t.rdy = a_rdy; t.res = 20'(a_res); t.mis = 20'(a_mis); t.flush = a_fl;
        t.er0 = x_r0; t.er1 = x_r1; t.ev = x_ev; t.erob = 7'(x_rob);
        t.emask = 20'(x_mask); t.esrc = x_src; t.ekill = 16'(x_kill);
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic set_idle();
        v0 = 0; v1 = 0; rob0 = '0; rob1 = '0; pdst0 = '0; pdst1 = '0;
        m0 = '0; m1 = '0; exe_rdy = 0; res = '0; mis = '0; flush = 0;
    endtask

    // Check DUT against the model for the current (settled) inputs, then advance the model
    task automatic model_step();
        bit held_kill, free, in_kill;
        int g;
        bit [19:0] gmask;
        held_kill = md_valid && (((md_mask & mis) != 0) || flush);
        free = !md_valid || exe_rdy || held_kill;
        g = -1;
        if (!rst && free && !flush) begin
            if (v0 && v1) g = md_rr;
            else if (v0) g = 0;
            else if (v1) g = 1;
        end
        chk("m_ready0", 32'(r0), 32'(g == 0));
        chk("m_ready1", 32'(r1), 32'(g == 1));
        chk("m_exe_valid", 32'(ev), 32'(md_valid));
        if (md_valid) begin
            chk("m_rob", 32'(erob), 32'(md_rob));
            chk("m_pdst", 32'(epdst), 32'(md_pdst));
            chk("m_mask", 32'(emask), 32'(md_mask));
            chk("m_src", 32'(esrc), 32'(md_src));
        end
        chk("m_kill", 32'(kcnt), 32'(md_kill));

        gmask = (g == 1) ? m1 : m0;
        in_kill = (g >= 0) && ((gmask & mis) != 0);
        if (rst) begin
            md_valid = 0; md_rr = 0; md_kill = 0;
        end else begin
            if ((held_kill || in_kill) && md_kill < 65535) md_kill++;
            if (g >= 0) md_rr = 1 - g;
            if (g >= 0 && !in_kill) begin
                md_valid = 1;
                md_rob  = (g == 1) ? rob1 : rob0;
                md_pdst = (g == 1) ? pdst1 : pdst0;
                md_mask = gmask & ~res;
                md_src  = (g == 1);
            end else if (free) begin
                md_valid = 0;
            end else begin
                md_mask = md_mask & ~res;
            end
        end
    endtask

    initial begin
        vecs[0]  = mk(1, 1, 0,    1, 2, 0,     1, 0, 0,    0,  1, 0, 0, 0, 0,    0, 0);
        vecs[1]  = mk(1, 3, 0,    1, 4, 0,     1, 0, 0,    0,  0, 1, 1, 1, 0,    0, 0);
        vecs[2]  = mk(1, 5, 0,    1, 6, 0,     1, 0, 0,    0,  1, 0, 1, 4, 0,    1, 0);
        vecs[3]  = mk(0, 0, 0,    0, 0, 0,     1, 0, 0,    0,  0, 0, 1, 5, 0,    0, 0);
        vecs[4]  = mk(1, 5, 0,    0, 0, 0,     0, 0, 0,    0,  1, 0, 0, 0, 0,    0, 0);
        vecs[5]  = mk(1, 7, 0,    1, 8, 0,     0, 0, 0,    0,  0, 0, 1, 5, 0,    0, 0);
        vecs[6]  = mk(1, 7, 0,    1, 8, 0,     0, 0, 0,    0,  0, 0, 1, 5, 0,    0, 0);
        vecs[7]  = mk(1, 7, 0,    1, 8, 0,     0, 0, 0,    0,  0, 0, 1, 5, 0,    0, 0);
        vecs[8]  = mk(1, 7, 0,    1, 8, 0,     1, 0, 0,    0,  0, 1, 1, 5, 0,    0, 0);
        vecs[9]  = mk(0, 0, 0,    0, 0, 0,     1, 0, 0,    0,  0, 0, 1, 8, 0,    1, 0);
        vecs[10] = mk(1, 9, 3,    0, 0, 0,     0, 0, 0,    0,  1, 0, 0, 0, 0,    0, 0);
        vecs[11] = mk(0, 0, 0,    0, 0, 0,     0, 1, 0,    0,  0, 0, 1, 9, 3,    0, 0);
        vecs[12] = mk(0, 0, 0,    0, 0, 0,     0, 0, 2,    0,  0, 0, 1, 9, 2,    0, 0);
        vecs[13] = mk(0, 0, 0,    1, 11, 'h10, 0, 0, 'h10, 0,  0, 1, 0, 0, 0,    0, 1);
        vecs[14] = mk(1, 10, 0,   0, 0, 0,     0, 0, 0,    0,  1, 0, 0, 0, 0,    0, 2);
        vecs[15] = mk(1, 13, 0,   1, 14, 0,    0, 0, 0,    1,  0, 0, 1, 10, 0,   0, 2);
        vecs[16] = mk(1, 11, 0,   1, 12, 'h80, 1, 0, 0,    0,  0, 1, 0, 0, 0,    0, 3);
        vecs[17] = mk(0, 0, 0,    0, 0, 0,     1, 0, 'h80, 0,  0, 0, 1, 12, 'h80, 1, 3);
        vecs[18] = mk(0, 0, 0,    0, 0, 0,     1, 0, 0,    0,  0, 0, 0, 0, 0,    0, 4);

        // reset with both requesters valid: no ready may rise
        rst = 1;
        set_idle();
        @(negedge clk);
        v0 = 1; v1 = 1;
        #1;
        chk("reset_ready0", 32'(r0), 32'd0);
        chk("reset_ready1", 32'(r1), 32'd0);
        md_valid = 0; md_rr = 0; md_kill = 0; md_rob = '0; md_pdst = '0; md_mask = '0; md_src = 0;

        // directed vector table
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            rst = 0;
            v0 = vecs[i].v0; rob0 = vecs[i].rob0; m0 = vecs[i].m0; pdst0 = vecs[i].rob0 + 7'd32;
            v1 = vecs[i].v1; rob1 = vecs[i].rob1; m1 = vecs[i].m1; pdst1 = vecs[i].rob1 + 7'd64;
            exe_rdy = vecs[i].rdy; res = vecs[i].res; mis = vecs[i].mis; flush = vecs[i].flush;
            #1;
            chk($sformatf("v%0d_ready0", i), 32'(r0), 32'(vecs[i].er0));
            chk($sformatf("v%0d_ready1", i), 32'(r1), 32'(vecs[i].er1));
            chk($sformatf("v%0d_exe_valid", i), 32'(ev), 32'(vecs[i].ev));
            if (vecs[i].ev) begin
                chk($sformatf("v%0d_rob", i), 32'(erob), 32'(vecs[i].erob));
                chk($sformatf("v%0d_mask", i), 32'(emask), 32'(vecs[i].emask));
                chk($sformatf("v%0d_src", i), 32'(esrc), 32'(vecs[i].esrc));
            end
            chk($sformatf("v%0d_kill", i), 32'(kcnt), 32'(vecs[i].ekill));
            model_step();
        end

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 99) == 0);
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 2) != 0);
            rob0 = 7'($urandom); rob1 = 7'($urandom);
            pdst0 = 7'($urandom); pdst1 = 7'($urandom);
            m0 = 20'($urandom & 32'hF); m1 = 20'($urandom & 32'hF);
            exe_rdy = ($urandom_range(0, 2) != 0);
            res = 20'($urandom & 32'hF);
            mis = ($urandom_range(0, 5) == 0) ? 20'(32'd1 << $urandom_range(0, 3)) : 20'd0;
            flush = ($urandom_range(0, 19) == 0);
            #1;
            model_step();
        end

        // saturation: one incoming kill per cycle
        @(negedge clk);
        set_idle();
        rst = 1;
        @(negedge clk);
        rst = 0; v0 = 1; m0 = 20'd1; mis = 20'd1; exe_rdy = 1;
        for (int i = 0; i < 65534; i++) @(negedge clk);
        #1;
        chk("sat_fffe", 32'(kcnt), 32'hFFFE);
        @(negedge clk);
        #1;
        chk("sat_ffff", 32'(kcnt), 32'hFFFF);
        chk("sat_no_exe", 32'(ev), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("sat_hold", 32'(kcnt), 32'hFFFF);
        rst = 1;
        @(negedge clk);
        #1;
        chk("sat_reset", 32'(kcnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
